// File: rtl/mem_bist_march.sv
// March-test BIST engine (MATS+ or March C-) for a single-port synchronous memory.
// Each read is checked one cycle after its strobe; results stay put until the next start.
module mem_bist_march #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned AD_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  output logic [AD_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [AD_WIDTH-1:0]   fail_addr,
  output logic [2:0]            fail_element,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  // A two-op element is always (read val, write ~val); a one-op element is a lone read or write.
  typedef struct packed {
    logic last;
    logic down;
    logic two;
    logic rd_first;
    logic val;
  } elem_t;

  localparam logic [AD_WIDTH-1:0] AddrMax = {AD_WIDTH{1'b1}};
  localparam logic [AD_WIDTH-1:0] AddrOne = AD_WIDTH'(1);

  function automatic logic elem_down(input logic m, input logic [2:0] e);
    return m ? (e == 3'd3 || e == 3'd4) : (e == 3'd2);
  endfunction

  function automatic elem_t elem_info(input logic m, input logic [2:0] e);
    elem_t r;
    r.last     = m ? (e == 3'd5) : (e == 3'd2);
    r.down     = elem_down(m, e);
    r.two      = (e != 3'd0) && !(m && e == 3'd5);
    r.rd_first = (e != 3'd0);
    r.val      = m ? (e == 3'd2 || e == 3'd4) : (e == 3'd2);
    return r;
  endfunction

  state_e                state_q, state_d;
  logic                  mode_q, mode_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_q, op_d;
  logic [AD_WIDTH-1:0]   addr_q, addr_d;
  logic                  pend_q, pend_d;
  logic                  exp_q, exp_d;
  logic [AD_WIDTH-1:0]   cmp_addr_q, cmp_addr_d;
  logic [2:0]            cmp_elem_q, cmp_elem_d;
  logic                  fail_q, fail_d;
  logic [AD_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;
  logic [7:0]            err_q, err_d;

  elem_t                 cur;
  logic                  op_rd;
  logic                  op_val;
  logic                  op_end;
  logic                  el_end;
  logic                  run;

  always_comb begin
    cur    = elem_info(mode_q, elem_q);
    op_rd  = cur.rd_first & ~op_q;
    op_val = op_q ? ~cur.val : cur.val;
    op_end = ~cur.two | op_q;
    el_end = cur.down ? (addr_q == '0) : (addr_q == AddrMax);
    run    = (state_q == StRun);
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    pend_d      = 1'b0;
    exp_d       = exp_q;
    cmp_addr_d  = cmp_addr_q;
    cmp_elem_d  = cmp_elem_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    err_d       = err_q;

    if (pend_q && (mem_rdata != {DATA_WIDTH{exp_q}})) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (!fail_q) begin
        fail_d      = 1'b1;
        fail_addr_d = cmp_addr_q;
        fail_elem_d = cmp_elem_q;
      end
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          mode_d      = mode;
          elem_d      = 3'd0;
          op_d        = 1'b0;
          addr_d      = '0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = 3'd0;
          err_d       = 8'd0;
        end
      end
      StRun: begin
        pend_d     = op_rd;
        exp_d      = op_val;
        cmp_addr_d = addr_q;
        cmp_elem_d = elem_q;
        if (!op_end) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!el_end) begin
            addr_d = cur.down ? addr_q - AddrOne : addr_q + AddrOne;
          end else if (cur.last) begin
            state_d = StDrain;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = elem_down(mode_q, elem_q + 3'd1) ? AddrMax : '0;
          end
        end
      end
      StDrain: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      elem_q      <= 3'd0;
      op_q        <= 1'b0;
      addr_q      <= '0;
      pend_q      <= 1'b0;
      exp_q       <= 1'b0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= 3'd0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      err_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      pend_q      <= pend_d;
      exp_q       <= exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    mem_we       = run & ~op_rd;
    mem_re       = run & op_rd;
    mem_addr     = run ? addr_q : '0;
    mem_wdata    = (run & ~op_rd) ? {DATA_WIDTH{op_val}} : '0;
    busy         = run | (state_q == StDrain);
    done         = (state_q == StDone);
    fail         = fail_q;
    fail_addr    = fail_addr_q;
    fail_element = fail_elem_q;
    err_count    = err_q;
  end

endmodule

// File: doc/mem_bist_march.md
MEM_BIST_MARCH -- requirements
Module: mem_bist_march

Interface
REQ-001 SHALL take parameter DATA_WIDTH, default 8, memory word width in bits.
REQ-002 SHALL take parameter AD_WIDTH, default 4, memory address width; N = 2**AD_WIDTH words are tested.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  run request, sampled only while idle or done.
REQ-006 mode  input  1  algorithm select: 0 = MATS+, 1 = March C-; sampled with start.
REQ-007 mem_addr  output  AD_WIDTH  memory address.
REQ-008 mem_wdata  output  DATA_WIDTH  write data: all-0 or all-1.
REQ-009 mem_we  output  1  write strobe, one cycle per write.
REQ-010 mem_re  output  1  read strobe; mem_rdata is valid the cycle after.
REQ-011 mem_rdata  input  DATA_WIDTH  memory read data.
REQ-012 busy  output  1  test in progress.
REQ-013 done  output  1  test complete; held until next start or reset.
REQ-014 fail  output  1  sticky: at least one read mismatch in this run.
REQ-015 fail_addr  output  AD_WIDTH  address of the first mismatch.
REQ-016 fail_element  output  3  March element index (0-based) of the first mismatch.
REQ-017 err_count  output  8  mismatch count, saturating at 255.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start=1 -> RUN.
- RUN, last op issued -> DRAIN.
- DRAIN -> DONE after one cycle.
REQ-019 March C- elements SHALL be:
- 0: up(w0)
- 1: up(r0,w1)
- 2: up(r1,w0)
- 3: down(r0,w1)
- 4: down(r1,w0)
- 5: up(r0)
- Total ops = 10N.
REQ-020 MATS+ elements SHALL be:
- 0: up(w0)
- 1: up(r0,w1)
- 2: down(r1,w0)
- Total ops = 5N.
REQ-021 Address order SHALL be:
- up: 0 to N-1.
- down: N-1 to 0.
- All ops of an element at one address are issued before the address steps.
REQ-022 Op issue SHALL be exactly one op per RUN cycle, no idle cycles between ops; mem_we and mem_re are never both 1.
REQ-023 Data values SHALL be:
- "0" = all bits 0, "1" = all bits 1 over DATA_WIDTH.
- Each read's expected value, address and element index are registered with mem_re.
REQ-024 Compare SHALL occur the cycle after mem_re. On mismatch:
- err_count increments, saturating at 255.
- If fail was 0, then fail=1 and fail_addr/fail_element capture the registered address and element.
REQ-025 A mismatch SHALL NOT abort the run; all ops complete.
REQ-026 Timing: start=1 sampled at edge T -> busy=1 and first op during cycle T+1; ops occupy cycles T+1..T+OPS; DRAIN at T+OPS+1 performs the final compare; done=1 and busy=0 from T+OPS+2.
REQ-027 start while RUN or DRAIN SHALL be ignored; mode changes during a run SHALL be ignored.
REQ-028 start in DONE SHALL clear done, fail, fail_addr, fail_element and err_count on the same edge that enters RUN.
REQ-029 mem_we, mem_re, mem_addr and mem_wdata SHALL be 0 outside RUN.

Reset
REQ-030 rst=0 at any edge, including mid-run, SHALL force:
- state IDLE;
- busy, done, fail, mem_we, mem_re = 0;
- mem_addr, mem_wdata, fail_addr, fail_element, err_count = 0;
- in-flight compare discarded.
REQ-031 After rst returns to 1, no op SHALL issue until a new start.

Verification (DATA_WIDTH=8, AD_WIDTH=3, N=8; start pulsed at edge 0)
REQ-032 Fault-free memory, mode=1 -> 80 op cycles; done=1 at cycle 82; fail=0; err_count=0.
REQ-033 Bit0 stuck-at-1 at address 5, mode=1 -> fail=1, fail_addr=5, fail_element=1, err_count=3, done at cycle 82.
REQ-034 Fault-free memory, mode=0 -> first mem_addr sequence 0..7 writes of 0x00; done=1 at cycle 42; element 2 reads 0xFF at addresses 7 down to 0.
REQ-035 rst=0 at cycle 30 of a run -> next cycle busy=0, mem_we=0, mem_re=0, err_count=0; a new start yields a full run, done at cycle 82 relative to that start.
REQ-036 start re-pulsed at cycle 10 of a run -> ignored, done still at cycle 82; then start in DONE after a failing run -> fail and err_count cleared the same edge, busy=1 next cycle.
